register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Multi-ported successor to the single-write/dual-read integer register file.
//  Supports NUM_RD registered read ports and NUM_WR write ports, with x0 hardwired to zero inside the block.
//  Adds write-to-read bypass and a per-register busy scoreboard for the pipelined/dual-issue core.
//  Sits between decode (read/reserve) and writeback (write/clear).
// PARAMETERS
//  DATAW     32            register width
//  NUM_REGS  32            register count (power of two, >=2)
//  ADDRW     $clog2(NUM_REGS)  register index width
//  NUM_RD    2             read ports (>=1)
//  NUM_WR    1             write ports (>=1)
//  SP_INDEX  2             register loaded with SP_INIT at reset
//  SP_INIT   32'h01000000 + `MEM_DEPTH   stack pointer reset value
// PORTS
//  clock     in   1               all state updates on posedge
//  reset_n   in   1               synchronous, active-low reset
//  rd_addr   in   NUM_RD*ADDRW    read indices, port i at [i*ADDRW +: ADDRW]
//  rd_data   out  NUM_RD*DATAW    registered read data, port i at [i*DATAW +: DATAW]
//  rd_busy   out  NUM_RD          registered scoreboard bit for port i's register
//  wr_en     in   NUM_WR          write enable per write port
//  wr_addr   in   NUM_WR*ADDRW    write indices
//  wr_data   in   NUM_WR*DATAW    write data
//  rsv_en    in   1               reserve (mark busy) a destination register
//  rsv_addr  in   ADDRW           register to reserve
//  busy_vec  out  NUM_REGS        current scoreboard state, bit 0 always 0
// BEHAVIOUR
//  Reset (reset_n==0 at posedge) dominates every other input that cycle:
//  - All regs are set to 0, except regs[SP_INDEX]=SP_INIT.
//  - rd_data=0, rd_busy=0, busy_vec=0.
//  Write: at posedge, each port j with wr_en[j] && wr_addr!=0 updates its reg.
//  - Same-address conflict: highest-index write port wins.
//  - Writes to x0 are dropped; regs[0] is never nonzero.
//  Read latency is exactly 1 cycle. rd_data[i] is registered at posedge as follows:
//  - rd_addr==0: 0.
//  - Else, if any enabled write to the same address occurs this cycle: wr_data of the highest such j (write-first bypass).
//  - Else: regs[rd_addr].
//  Scoreboard busy[k] update:
//  - Cleared at posedge by any enabled write to k.
//  - Set at posedge by rsv_en with rsv_addr==k.
//  - Reserve and write to the same k in one cycle: reserve wins, busy=1 (new producer).
//  - Reserve or write with address 0 is ignored; busy[0] stays 0.
//  rd_busy[i] is registered with rd_data[i]:
//  - Equals busy[rd_addr] after this cycle's write-clear.
//  - Excludes this cycle's reservation, so it is consistent with the bypassed data.
//  - rd_busy for address 0 is 0.
//  busy_vec is a direct register output (no combinational path from inputs).
//  Reads with no write are non-destructive. Holding rd_addr re-reads the same value every cycle.
//  Reset asserted mid-stream discards in-flight writes/reservations for that edge.
//  First post-reset read of SP_INDEX returns SP_INIT.
//  No X propagation: all storage has a defined reset value.
// TESTING
//  1. Reset, then read x2 and x5 -> rd_data=SP_INIT and 0 one cycle later; busy_vec=0.
//  2. wr x7=0xDEADBEEF while reading x7 same cycle -> rd_data=0xDEADBEEF next cycle (bypass); re-read -> same.
//  3. NUM_WR=2: both ports write x9 (0x11, 0x22) -> x9 reads 0x22. Write x0=0xFFFF -> x0 reads 0.
//  4. rsv x4 -> busy_vec[4]=1. Read x4 -> rd_busy=1. Write x4=5 with read x4 same cycle -> rd_data=5, rd_busy=0, busy_vec[4]=0.
//  5. rsv x4 and write x4 same cycle -> busy_vec[4]=1. rsv x0 -> busy_vec[0]=0.
//  6. Write x3=0xA5 and rsv x6 with reset_n=0 same edge -> x3 reads 0, busy_vec=0, x2=SP_INIT.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Decode/writeback-facing bus of the multi-ported register file.
// All vectors are flat; port i occupies [i*W +: W].
interface register_file_mp_if #(
  parameter int DATAW    = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDRW    = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);
  logic [NUM_RD*ADDRW-1:0] rd_addr;
  logic [NUM_RD*DATAW-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*ADDRW-1:0] wr_addr;
  logic [NUM_WR*DATAW-1:0] wr_data;
  logic                    rsv_en;
  logic [ADDRW-1:0]        rsv_addr;
  logic [NUM_REGS-1:0]     busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port integer register file with x0 pinned to zero, write-first
// read bypass and a per-register busy scoreboard.
`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0000_4000
`endif

module register_file_mp #(
  parameter int               DATAW    = 32,
  parameter int               NUM_REGS = 32,
  parameter int               ADDRW    = $clog2(NUM_REGS),
  parameter int               NUM_RD   = 2,
  parameter int               NUM_WR   = 1,
  parameter int               SP_INDEX = 2,
  parameter logic [DATAW-1:0] SP_INIT  = DATAW'(32'h0100_0000 + `MEM_DEPTH)
) (
  input logic               clock,
  input logic               reset_n,
  register_file_mp_if.slave bus
);

  logic [NUM_REGS-1:0][DATAW-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            busy_q, busy_d, busy_clr;

  // regs_d is the post-write register image, so reading it gives the
  // write-first bypass for free; ascending j lets the highest port win.
  always_comb begin
    regs_d   = regs_q;
    busy_clr = busy_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j]) begin
        regs_d[bus.wr_addr[j*ADDRW +: ADDRW]]   = bus.wr_data[j*DATAW +: DATAW];
        busy_clr[bus.wr_addr[j*ADDRW +: ADDRW]] = 1'b0;
      end
    end
    regs_d[0]   = '0;
    busy_clr[0] = 1'b0;
    // Reservation applied after the clear: a new producer beats the old one.
    busy_d = busy_clr;
    if (bus.rsv_en) busy_d[bus.rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      regs_q           <= '0;
      regs_q[SP_INDEX] <= SP_INIT;
      busy_q           <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign bus.busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] rd_data_q, rd_data_d;
    logic             rd_busy_q, rd_busy_d;

    assign addr = bus.rd_addr[i*ADDRW +: ADDRW];

    // Entry 0 of both images is pinned to zero, so x0 reads need no special case.
    always_comb begin
      rd_data_d = regs_d[addr];
      rd_busy_d = busy_clr[addr];
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        rd_data_q <= '0;
        rd_busy_q <= 1'b0;
      end else begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= rd_busy_d;
      end
    end

    assign bus.rd_data[i*DATAW +: DATAW] = rd_data_q;
    assign bus.rd_busy[i]                = rd_busy_q;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp (2 read / 2 write ports): directed table,
// hand sequences, then random traffic against a behavioural model.
`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0000_4000
`endif

module tb_register_file_mp;
  localparam logic [31:0] SP = 32'h0100_0000 + `MEM_DEPTH;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  register_file_mp_if #(.DATAW(32), .NUM_REGS(32), .ADDRW(5), .NUM_RD(2), .NUM_WR(2)) bus ();
  register_file_mp #(.DATAW(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    bit          rst_n;
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    bit          rsv;
    logic [4:0]  rsa;
    logic [31:0] e0, e1;
    logic        eb0, eb1;
    logic [31:0] ebv;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mregs [32];
  logic [31:0] mbusy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: highest-numbered enabled write to an address is the one that lands.
  function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (v.we[1] && v.wa1 == a) return v.wd1;
    if (v.we[0] && v.wa0 == a) return v.wd0;
    return mregs[a];
  endfunction

  function automatic logic m_busy(input vec_t v, input logic [4:0] a);
    if (a == 0) return 1'b0;
    if ((v.we[1] && v.wa1 == a) || (v.we[0] && v.wa0 == a)) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic cycle(input vec_t v, input bit use_tbl, input string tag);
    logic [31:0] x0, x1, nb;
    logic        b0, b1;
    logic [31:0] nregs [32];
    reset_n         = v.rst_n;
    bus.rd_addr     = {v.ra1, v.ra0};
    bus.wr_en       = v.we;
    bus.wr_addr     = {v.wa1, v.wa0};
    bus.wr_data     = {v.wd1, v.wd0};
    bus.rsv_en      = v.rsv;
    bus.rsv_addr    = v.rsa;
    if (!v.rst_n) begin
      x0 = 0; x1 = 0; b0 = 0; b1 = 0; nb = 0;
      for (int k = 0; k < 32; k++) nregs[k] = 0;
      nregs[2] = SP;
    end else begin
      x0 = m_read(v, v.ra0); x1 = m_read(v, v.ra1);
      b0 = m_busy(v, v.ra0); b1 = m_busy(v, v.ra1);
      for (int k = 0; k < 32; k++) nregs[k] = m_read(v, 5'(k));
      nb = 0;
      for (int k = 1; k < 32; k++) nb[k] = m_busy(v, 5'(k));
      if (v.rsv && v.rsa != 0) nb[v.rsa] = 1'b1;
    end
    @(posedge clock);
    #1;
    if (use_tbl) begin
      chk({tag, ".rd0"},   bus.rd_data[31:0],  v.e0);
      chk({tag, ".rd1"},   bus.rd_data[63:32], v.e1);
      chk({tag, ".busy0"}, {31'h0, bus.rd_busy[0]}, {31'h0, v.eb0});
      chk({tag, ".busy1"}, {31'h0, bus.rd_busy[1]}, {31'h0, v.eb1});
      chk({tag, ".bvec"},  bus.busy_vec, v.ebv);
    end else begin
      chk({tag, ".rd0"},   bus.rd_data[31:0],  x0);
      chk({tag, ".rd1"},   bus.rd_data[63:32], x1);
      chk({tag, ".busy0"}, {31'h0, bus.rd_busy[0]}, {31'h0, b0});
      chk({tag, ".busy1"}, {31'h0, bus.rd_busy[1]}, {31'h0, b1});
      chk({tag, ".bvec"},  bus.busy_vec, nb);
    end
    for (int k = 0; k < 32; k++) mregs[k] = nregs[k];
    mbusy = nb;
  endtask

  function automatic vec_t mk(input bit rst_n, input logic [4:0] ra0, ra1,
                              input logic [1:0] we, input logic [4:0] wa0, wa1,
                              input logic [31:0] wd0, wd1, input bit rsv, input logic [4:0] rsa,
                              input logic [31:0] e0, e1, input logic eb0, eb1,
                              input logic [31:0] ebv);
    vec_t v;
    v.rst_n = rst_n; v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa0 = wa0; v.wa1 = wa1;
    v.wd0 = wd0; v.wd1 = wd1; v.rsv = rsv; v.rsa = rsa;
    v.e0 = e0; v.e1 = e1; v.eb0 = eb0; v.eb1 = eb1; v.ebv = ebv;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    vec_t v;
    for (int k = 0; k < 32; k++) mregs[k] = 0;
    mbusy = 0;
    bus.rd_addr = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.rsv_en = 0; bus.rsv_addr = 0;

    //            rst ra0 ra1 we    wa0 wa1 wd0            wd1       rsv rsa  e0             e1            eb0 eb1 bvec
    tbl[0]  = mk(0, 2, 5, 2'b00, 0, 0, 0,             0,        0, 0,  0,             0,            0, 0, 0);
    tbl[1]  = mk(1, 2, 5, 2'b00, 0, 0, 0,             0,        0, 0,  SP,            0,            0, 0, 0);
    tbl[2]  = mk(1, 7, 7, 2'b01, 7, 0, 32'hDEADBEEF,  0,        0, 0,  32'hDEADBEEF,  32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(1, 7, 2, 2'b00, 0, 0, 0,             0,        0, 0,  32'hDEADBEEF,  SP,           0, 0, 0);
    tbl[4]  = mk(1, 9, 0, 2'b11, 9, 9, 32'h11,        32'h22,   0, 0,  32'h22,        0,            0, 0, 0);
    tbl[5]  = mk(1, 9, 9, 2'b00, 0, 0, 0,             0,        0, 0,  32'h22,        32'h22,       0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 2'b01, 0, 0, 32'hFFFF,      0,        0, 0,  0,             0,            0, 0, 0);
    tbl[7]  = mk(1, 0, 9, 2'b00, 0, 0, 0,             0,        0, 0,  0,             32'h22,       0, 0, 0);
    tbl[8]  = mk(1, 4, 4, 2'b00, 0, 0, 0,             0,        1, 4,  0,             0,            0, 0, 32'h10);
    tbl[9]  = mk(1, 4, 1, 2'b00, 0, 0, 0,             0,        0, 0,  0,             0,            1, 0, 32'h10);
    tbl[10] = mk(1, 4, 4, 2'b01, 4, 0, 32'h5,         0,        0, 0,  32'h5,         32'h5,        0, 0, 0);
    tbl[11] = mk(1, 4, 3, 2'b01, 4, 0, 32'h6,         0,        1, 4,  32'h6,         0,            0, 0, 32'h10);
    tbl[12] = mk(1, 4, 0, 2'b00, 0, 0, 0,             0,        1, 0,  32'h6,         0,            1, 0, 32'h10);
    tbl[13] = mk(0, 3, 2, 2'b10, 0, 3, 0,             32'hA5,   1, 6,  0,             0,            0, 0, 0);
    tbl[14] = mk(1, 3, 2, 2'b00, 0, 0, 0,             0,        0, 0,  0,             SP,           0, 0, 0);
    tbl[15] = mk(1, 4, 9, 2'b00, 0, 0, 0,             0,        0, 0,  0,             0,            0, 0, 0);
    tbl[16] = mk(1, 5, 6, 2'b11, 5, 6, 32'hAAAA,      32'hBBBB, 1, 5,  32'hAAAA,      32'hBBBB,     0, 0, 32'h20);

    for (int i = 0; i < 17; i++) cycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Hold a read address across several idle cycles after a single write.
    cycle(mk(1, 10, 0, 2'b10, 0, 10, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0), 1'b0, "hold_wr");
    for (int i = 0; i < 4; i++)
      cycle(mk(1, 10, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "hold_rd");
    chk("hold_val", bus.rd_data[31:0], 32'h1234);

    // Reserve then release across ports, with reserve on the same edge as release elsewhere.
    cycle(mk(1, 12, 0, 2'b00, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0), 1'b0, "rsv12");
    cycle(mk(1, 12, 12, 2'b10, 0, 12, 0, 32'h77, 1, 13, 0, 0, 0, 0, 0), 1'b0, "rel12");

    for (int i = 0; i < 400; i++) begin
      v.rst_n = ($urandom_range(0, 49) != 0);
      v.ra0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      v.ra1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      v.we  = 2'($urandom);
      v.wa0 = 5'($urandom_range(0, 7));
      v.wa1 = ($urandom_range(0, 1) != 0) ? v.wa0 : 5'($urandom);
      v.wd0 = $urandom; v.wd1 = $urandom;
      v.rsv = ($urandom_range(0, 2) == 0);
      v.rsa = 5'($urandom_range(0, 7));
      v.e0 = 0; v.e1 = 0; v.eb0 = 0; v.eb1 = 0; v.ebv = 0;
      cycle(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
